// File: rtl/keypad_pkg.sv
// Shared types, column drive patterns and key map for the decimal keypad scanner.
package keypad_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_SCAN     = 2'd0;
  localparam state_t ST_DEBOUNCE = 2'd1;
  localparam state_t ST_PRESSED  = 2'd2;
  localparam state_t ST_RELEASE  = 2'd3;

  localparam int unsigned ROWS     = 4;
  localparam int unsigned COLS     = 3;
  localparam int unsigned DIGITS   = 10;

  // Active-low column drive, indexed by column number.
  localparam logic [COLS-1:0][COLS-1:0] COL_PAT = {3'b011, 3'b101, 3'b110};

  // One-hot digit per (row, col); '*' and '#' map to zero.
  localparam logic [ROWS-1:0][COLS-1:0][DIGITS-1:0] KEY_MAP = {
    {10'b0000000000, 10'b0000000001, 10'b0000000000},  // row3: #, 0, *
    {10'b1000000000, 10'b0100000000, 10'b0010000000},  // row2: 9, 8, 7
    {10'b0001000000, 10'b0000100000, 10'b0000010000},  // row1: 6, 5, 4
    {10'b0000001000, 10'b0000000100, 10'b0000000010}   // row0: 3, 2, 1
  };

  // True when exactly one row line is low.
  function automatic logic single_low(input logic [ROWS-1:0] r);
    case (r)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
      default:                            single_low = 1'b0;
    endcase
  endfunction

  // Index of the low row; only meaningful when single_low() holds.
  function automatic logic [1:0] low_row(input logic [ROWS-1:0] r);
    case (r)
      4'b1101: low_row = 2'd1;
      4'b1011: low_row = 2'd2;
      4'b0111: low_row = 2'd3;
      default: low_row = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchronizer for asynchronous inputs; resets to all ones.
module bit_synchronizer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // Next-state: shift the raw input through two stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/decimal_keypad_scanner.sv
// 4x3 keypad scanner with press/release debounce and decimal one-hot output.
module decimal_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [2:0] col_n,
  output logic [9:0] key_onehot,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       rs;
  state_t           state_q, state_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [1:0]       row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       col_n_q, col_n_d;
  logic [9:0]       onehot_q, onehot_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;
  logic [1:0]       col_next;
  logic [3:0]       row_pat;
  logic [9:0]       map_val;

  bit_synchronizer #(.WIDTH(4)) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_n),
    .q     (rs)
  );

  // Helper terms: next column, expected row pattern, digit for the latched key.
  always_comb begin
    col_next = (col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1;
    row_pat  = ~(4'b0001 << row_q);
    map_val  = KEY_MAP[row_q][col_idx_q];
  end

  // Scan / debounce FSM next-state and output logic.
  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    onehot_d  = onehot_q;
    valid_d   = 1'b0;
    held_d    = held_q;

    case (state_q)
      ST_SCAN: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (single_low(rs)) begin
            row_d   = low_row(rs);
            state_d = ST_DEBOUNCE;
          end else begin
            col_idx_d = col_next;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DEBOUNCE: begin
        if (rs == row_pat) begin
          if (cnt_q == DEB_LAST) begin
            cnt_d    = '0;
            state_d  = ST_PRESSED;
            held_d   = 1'b1;
            onehot_d = map_val;
            valid_d  = |map_val;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d     = '0;
          state_d   = ST_SCAN;
          col_idx_d = col_next;
        end
      end

      ST_PRESSED: begin
        if (rs[row_q]) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (rs[row_q]) begin
          if (cnt_q == DEB_LAST) begin
            cnt_d     = '0;
            onehot_d  = '0;
            held_d    = 1'b0;
            state_d   = ST_SCAN;
            col_idx_d = col_next;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d   = '0;
          state_d = ST_PRESSED;
        end
      end

      default: begin
        state_d   = ST_SCAN;
        cnt_d     = '0;
        col_idx_d = 2'd0;
      end
    endcase

    col_n_d = COL_PAT[col_idx_d];
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SCAN;
      col_idx_q <= 2'd0;
      row_q     <= 2'd0;
      cnt_q     <= '0;
      col_n_q   <= 3'b110;
      onehot_q  <= '0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      col_n_q   <= col_n_d;
      onehot_q  <= onehot_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
    end
  end

  assign col_n      = col_n_q;
  assign key_onehot = onehot_q;
  assign key_valid  = valid_q;
  assign key_held   = held_q;

endmodule

// File: tb/tb_decimal_keypad_scanner.sv
// Scoreboard bench for decimal_keypad_scanner with a behavioural keypad matrix.
module tb_decimal_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row_n;
  logic [2:0] col_n;
  logic [9:0] key_onehot;
  logic       key_valid;
  logic       key_held;

  // Key closures, bit index = row*3 + col.
  logic [11:0] keys;

  int total = 0;
  int bad   = 0;
  logic [9:0] sb_q[$];

  decimal_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .row_n      (row_n),
    .col_n      (col_n),
    .key_onehot (key_onehot),
    .key_valid  (key_valid),
    .key_held   (key_held)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a closed key pulls its row low when its column is driven.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row_n[r] = ~|(keys[r*3 +: 3] & ~col_n);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic wait_col(input logic [2:0] pat);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (col_n == pat) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL wait_col: col_n never reached %b (last %b)", pat, col_n);
    end
  endtask

  task automatic check_drained(input string name);
    check(name, 10'(sb_q.size()), 10'd0);
  endtask

  initial begin
    logic [2:0] prev_col;
    rst_n = 1'b0;
    keys  = '0;

    // Monitor: every key_valid pulse pops one expected digit.
    fork
      begin
        logic prev_valid;
        logic [9:0] exp_v;
        prev_valid = 1'b0;
        forever begin
          @(negedge clk);
          if (rst_n && key_valid) begin
            check("valid_not_consecutive", 10'(prev_valid), 10'd0);
            total++;
            if (sb_q.size() == 0) begin
              bad++;
              $display("FAIL unexpected_pulse: got onehot %b expected no pulse", key_onehot);
            end else begin
              exp_v = sb_q.pop_front();
              if (key_onehot !== exp_v) begin
                bad++;
                $display("FAIL pulse_onehot: got %b expected %b", key_onehot, exp_v);
              end
            end
          end
          prev_valid = rst_n && key_valid;
        end
      end
    join_none

    // Reset state.
    cyc(3);
    check("rst_col_n", 10'(col_n), 10'(3'b110));
    check("rst_onehot", key_onehot, 10'd0);
    check("rst_valid", 10'(key_valid), 10'd0);
    check("rst_held", 10'(key_held), 10'd0);
    rst_n = 1'b1;

    // Clean press of digit 5 (row1, col1), aligned to col_n=101.
    wait_col(3'b101);
    keys[4] = 1'b1;
    sb_q.push_back(10'b0000100000);
    cyc(18);
    check("d5_onehot_held", key_onehot, 10'b0000100000);
    check("d5_held", 10'(key_held), 10'd1);
    check_drained("d5_pulse_seen");
    cyc(2);
    keys[4] = 1'b0;
    cyc(6);
    check("d5_onehot_releasing", key_onehot, 10'b0000100000);
    cyc(8);
    check("d5_onehot_cleared", key_onehot, 10'd0);
    check("d5_held_cleared", 10'(key_held), 10'd0);

    // Bouncing digit 1 (row0, col0): no pulse until it settles.
    for (int s = 0; s < 10; s++) begin
      keys[0] = (s % 2 == 0);
      cyc(3);
    end
    check("bounce_no_hold", 10'(key_held), 10'd0);
    keys[0] = 1'b1;
    sb_q.push_back(10'b0000000010);
    cyc(40);
    check("bounce_onehot", key_onehot, 10'b0000000010);
    check_drained("bounce_one_pulse");
    keys[0] = 1'b0;
    cyc(20);

    // Digit 0 (row3, col1) with a 2-cycle release glitch.
    keys[10] = 1'b1;
    sb_q.push_back(10'b0000000001);
    cyc(40);
    check("d0_onehot", key_onehot, 10'b0000000001);
    keys[10] = 1'b0;
    cyc(2);
    keys[10] = 1'b1;
    cyc(12);
    check("d0_glitch_onehot", key_onehot, 10'b0000000001);
    check("d0_glitch_held", 10'(key_held), 10'd1);
    keys[10] = 1'b0;
    cyc(4);
    check("d0_release_early", key_onehot, 10'b0000000001);
    cyc(12);
    check("d0_release_done", key_onehot, 10'd0);
    check_drained("d0_single_pulse");

    // Non-digit '#' (row3, col2).
    keys[11] = 1'b1;
    cyc(40);
    check("hash_held", 10'(key_held), 10'd1);
    check("hash_onehot", key_onehot, 10'd0);
    keys[11] = 1'b0;
    cyc(20);
    check("hash_released", 10'(key_held), 10'd0);

    // Two rows low on column 0 (keys 1 and 4): no capture, scanning continues.
    keys[0] = 1'b1;
    keys[3] = 1'b1;
    cyc(40);
    check("multi_no_hold", 10'(key_held), 10'd0);
    check("multi_onehot", key_onehot, 10'd0);
    prev_col = col_n;
    cyc(4);
    check("multi_scan_moves", 10'(col_n != prev_col), 10'd1);
    keys[0] = 1'b0;
    keys[3] = 1'b0;
    keys[8] = 1'b1;
    sb_q.push_back(10'b1000000000);
    cyc(40);
    check("d9_onehot", key_onehot, 10'b1000000000);
    keys[8] = 1'b0;
    cyc(20);

    // Reset mid-press of digit 8, then re-detection after release of reset.
    keys[7] = 1'b1;
    sb_q.push_back(10'b0100000000);
    cyc(40);
    check("d8_onehot", key_onehot, 10'b0100000000);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_col_n", 10'(col_n), 10'(3'b110));
    check("midrst_onehot", key_onehot, 10'd0);
    check("midrst_held", 10'(key_held), 10'd0);
    check("midrst_valid", 10'(key_valid), 10'd0);
    cyc(2);
    rst_n = 1'b1;
    sb_q.push_back(10'b0100000000);
    cyc(40);
    check("d8_redetect", key_onehot, 10'b0100000000);
    keys[7] = 1'b0;
    cyc(20);

    check_drained("final_drained");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
